// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the CPU MEM stage. It services word loads (LW)
//   and stores (SW) presented on a valid/ready request channel. Load data,
//   or a store acknowledge, comes back on a valid/ready response channel.
//   The RAM is word-addressed and synchronous, and a programmable number of
//   wait states separates request accept from the response.
//
//   Parameters
//     ADDR_LOG2    log2 of the number of 32-bit words held in the RAM
//     WAIT_STATES  extra cycles between request accept and response (0..15)
//
//   Ports
//     clk        in   1   clock, all logic on the rising edge
//     reset_n    in   1   synchronous reset, active low
//     req_valid  in   1   request present
//     req_ready  out  1   responder can accept a request (IDLE only)
//     req_write  in   1   1 = store, 0 = load
//     daddrbus   in   32  byte address; upper bits alias
//     databus    in   32  store data, sampled on accept
//     rsp_valid  out  1   response present (RESP only)
//     rsp_ready  in   1   consumer takes the response
//     rsp_rdata  out  32  load data; 0 for stores and errors
//     rsp_err    out  1   misaligned access (daddrbus[1:0] != 0)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_LOG2   = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] daddrbus,
  input  logic [31:0] databus,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 2 ** ADDR_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [3:0]             r_wait_cnt;
  logic                   r_write;
  logic                   r_err;
  logic [ADDR_LOG2-1:0]   r_index;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;
  logic                   r_rsp_err;
  logic [31:0]            r_mem [DEPTH];

  logic                   w_accept;
  logic                   w_access;
  logic                   w_unused_addr;

  // Address bits above the RAM index are ignored, so addresses alias.
  assign w_unused_addr = ^daddrbus[31:ADDR_LOG2+2];

  assign w_accept = (r_state == IDLE) && req_valid;
  // The access fires on the BUSY cycle in which the counter has run out.
  assign w_access = (r_state == BUSY) && (r_wait_cnt == 4'd0);

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values, regardless of the order of the blocks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so that no path
  // through the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = BUSY;
      end
      BUSY: begin
        if (w_access) w_next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wait_cnt <= 4'd0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_index    <= '0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_write    <= req_write;
      r_err      <= |daddrbus[1:0];
      r_index    <= daddrbus[ADDR_LOG2+1:2];
      r_wdata    <= databus;
      r_wait_cnt <= WAIT_INIT;
      r_rsp_err  <= 1'b0;
    end else if (r_state == BUSY) begin
      if (r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end else begin
        // Stores and errors return zero data; only a clean load reads RAM.
        r_rdata   <= (!r_write && !r_err) ? r_mem[r_index] : 32'd0;
        r_rsp_err <= r_err;
      end
    end
  end

  // NOTE: the RAM array has no reset; clearing it would turn a plain memory
  // into thousands of resettable flops, and its contents are undefined
  // until written. The write is gated by reset_n so that a store caught by
  // reset on its commit edge is dropped together with the rest of the
  // request.
  always_ff @(posedge clk) begin
    if (reset_n && w_access && r_write && !r_err) begin
      r_mem[r_index] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed self-checking bench for dmem_responder with ADDR_LOG2 = 6 and
//   WAIT_STATES = 2. Inputs are driven and outputs sampled on the falling
//   edge; the DUT works on the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] daddrbus;
  logic [31:0] databus;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          checks   = 0;
  int          failures = 0;
  int          last_lat;
  logic        busy_ready_seen;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_LOG2  (6),
    .WAIT_STATES(WS)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .daddrbus (daddrbus),
    .databus  (databus),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request, let it be accepted, then wait (bounded) for the
  // response. last_lat counts rising edges after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    daddrbus  = addr;
    databus   = data;
    @(negedge clk);
    req_valid       = 1'b0;
    last_lat        = 0;
    busy_ready_seen = req_ready;
    while (!rsp_valid && last_lat < 20) begin
      @(negedge clk);
      last_lat++;
      busy_ready_seen = busy_ready_seen | req_ready;
    end
    if (!rsp_valid) check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take(output logic [31:0] rdata, output logic err);
    rdata     = rsp_rdata;
    err       = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata, output logic err);
    issue(wr, addr, data);
    take(rdata, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    daddrbus  = 32'd0;
    databus   = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // 1 + 2: store then load, latency and ready behaviour.
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("sw_latency",       last_lat, 32'(1 + WS));
    check("sw_ready_busy",    {31'd0, busy_ready_seen}, 32'd0);
    take(rd, er);
    check("sw_rdata_zero",    rd, 32'd0);
    check("sw_err",           {31'd0, er}, 32'd0);
    check("idle_after_take",  {31'd0, req_ready}, 32'd1);
    check("valid_after_take", {31'd0, rsp_valid}, 32'd0);

    issue(1'b0, 32'h0000_0010, 32'h0);
    check("lw_latency",    last_lat, 32'(1 + WS));
    check("lw_ready_busy", {31'd0, busy_ready_seen}, 32'd0);
    take(rd, er);
    check("lw_rdata",      rd, 32'hDEAD_BEEF);
    check("lw_err",        {31'd0, er}, 32'd0);

    // 3: address aliasing modulo 256 bytes, both ends of the array.
    xact(1'b1, 32'h0000_0004, 32'h0000_0001, rd, er);
    xact(1'b0, 32'h0000_0104, 32'h0, rd, er);
    check("alias_104_rdata", rd, 32'h0000_0001);
    xact(1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, rd, er);
    xact(1'b0, 32'h0000_00FC, 32'h0, rd, er);
    check("alias_top_rdata", rd, 32'h0BAD_F00D);

    // 4: misaligned store is rejected and leaves RAM untouched.
    xact(1'b1, 32'h0000_0020, 32'hCAFE_0020, rd, er);
    xact(1'b1, 32'h0000_0022, 32'h0000_0055, rd, er);
    check("mis_sw_err",   {31'd0, er}, 32'd1);
    check("mis_sw_rdata", rd, 32'd0);
    xact(1'b0, 32'h0000_0020, 32'h0, rd, er);
    check("mis_prior_rdata", rd, 32'hCAFE_0020);
    check("err_cleared",     {31'd0, er}, 32'd0);
    xact(1'b0, 32'h0000_0021, 32'h0, rd, er);
    check("mis_lw_err",   {31'd0, er}, 32'd1);
    check("mis_lw_rdata", rd, 32'd0);

    // 5: response held for 5 cycles while a second request is offered.
    xact(1'b1, 32'h0000_0040, 32'h0000_1234, rd, er);
    issue(1'b0, 32'h0000_0010, 32'h0);
    req_valid = 1'b1;
    req_write = 1'b1;
    daddrbus  = 32'h0000_0040;
    databus   = 32'h0000_0777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("hold_err",   {31'd0, rsp_err}, 32'd0);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    take(rd, er);
    check("hold_take_rdata", rd, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    check("no_phantom_valid", {31'd0, rsp_valid}, 32'd0);
    check("no_phantom_ready", {31'd0, req_ready}, 32'd1);
    xact(1'b0, 32'h0000_0040, 32'h0, rd, er);
    check("ignored_sw_rdata", rd, 32'h0000_1234);

    // 6: reset during BUSY drops the store.
    xact(1'b1, 32'h0000_0030, 32'h0000_0011, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    daddrbus  = 32'h0000_0030;
    databus   = 32'h0000_00A5;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_busy_ready", {31'd0, req_ready}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rst_still_idle", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata_zero", rsp_rdata, 32'd0);
    xact(1'b0, 32'h0000_0030, 32'h0, rd, er);
    check("rst_old_value", rd, 32'h0000_0011);
    check("rst_lw_err",    {31'd0, er}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
